// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit: FSM states,
// exception codes and the redirect-target decode.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_REDIR = 2'd3
  } state_e;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] EXC_BASE_DEF = 32'hbfc0_0380;

  // Unknown nonzero codes still flush but redirect to address zero.
  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] base);
    logic [31:0] tgt;
    tgt = 32'h0000_0000;
    case (code)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV, EXC_TR: tgt = base;
      EXC_ERET:                        tgt = epc;
      default:                         tgt = 32'h0000_0000;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_mask_gen.sv
// Merges per-source stall requests into one stage mask: each active source
// freezes the lowest SRC_DEPTH[i] stages.
module stall_mask_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int                    STAGES    = 8,
  parameter int                    NSRC      = 3,
  parameter logic [8*NSRC-1:0]     SRC_DEPTH = {8'd4, 8'd5, 8'd7}
) (
  input  logic [NSRC-1:0]   stallreq,
  output logic [STAGES-1:0] mask
);

  function automatic logic [STAGES-1:0] thermo(input logic [7:0] depth);
    logic [STAGES-1:0] t;
    for (int k = 0; k < STAGES; k++) begin
      t[k] = (k < int'(depth));
    end
    return t;
  endfunction

  logic [STAGES-1:0] mask_s;

  // OR the thermometer of every requesting source
  always_comb begin
    mask_s = {STAGES{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (stallreq[i]) begin
        mask_s = mask_s | thermo(SRC_DEPTH[8*i +: 8]);
      end else begin
        mask_s = mask_s;
      end
    end
  end

  assign mask = mask_s;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall sources and sequences exception/ERET
// handling through wait, flush and redirect handshake phases.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                STAGES       = 8,
  parameter int                NSRC         = 3,
  parameter logic [8*NSRC-1:0] SRC_DEPTH    = {8'd4, 8'd5, 8'd7},
  parameter logic [NSRC-1:0]   BLOCK_MASK   = 3'b001,
  parameter int                FLUSH_CYCLES = 1,
  parameter logic [31:0]       EXC_BASE     = EXC_BASE_DEF,
  parameter int                CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  input  logic              redirect_ready_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              redirect_valid_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e            state_r, state_nx;
  logic [3:0]        flush_cnt_r, flush_cnt_nx;
  logic [31:0]       code_r, epc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [STAGES-1:0] mask_s, stall_s;
  logic              flush_s, load_exc_s, block_s;

  stall_mask_gen #(
    .STAGES    (STAGES),
    .NSRC      (NSRC),
    .SRC_DEPTH (SRC_DEPTH)
  ) u_mask (
    .stallreq (stallreq_i),
    .mask     (mask_s)
  );

  assign block_s = |(stallreq_i & BLOCK_MASK);

  // Next-state and combinational stall/flush decode
  always_comb begin
    state_nx     = state_r;
    flush_cnt_nx = flush_cnt_r;
    stall_s      = {STAGES{1'b0}};
    flush_s      = 1'b0;
    load_exc_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (excepttype_i != 32'd0) begin
          stall_s    = {STAGES{1'b1}};
          load_exc_s = 1'b1;
          if (block_s) begin
            state_nx = ST_WAIT;
          end else begin
            state_nx     = ST_FLUSH;
            flush_cnt_nx = FLUSH_LOAD;
          end
        end else begin
          stall_s = mask_s;
        end
      end
      ST_WAIT: begin
        stall_s = {STAGES{1'b1}};
        if (block_s) begin
          state_nx = ST_WAIT;
        end else begin
          state_nx     = ST_FLUSH;
          flush_cnt_nx = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        flush_s = 1'b1;
        // A count of one means this is the last flush cycle
        if (flush_cnt_r <= 4'd1) begin
          state_nx = ST_REDIR;
        end else begin
          flush_cnt_nx = flush_cnt_r - 4'd1;
        end
      end
      ST_REDIR: begin
        if (redirect_ready_i) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_REDIR;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // State, latched exception context and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 4'd0;
      code_r      <= 32'd0;
      epc_r       <= 32'd0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nx;
      flush_cnt_r <= flush_cnt_nx;
      if (load_exc_s) begin
        code_r <= excepttype_i;
        epc_r  <= cp0_epc_i;
      end
      if ((stall_s != {STAGES{1'b0}}) && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Output decode from the registered state
  always_comb begin
    stall_o          = stall_s;
    flush_o          = flush_s;
    busy_o           = (state_r != ST_RUN);
    redirect_valid_o = (state_r == ST_REDIR);
    if (state_r == ST_REDIR) begin
      new_pc_o = exc_target(code_r, epc_r, EXC_BASE);
    end else begin
      new_pc_o = 32'd0;
    end
  end

  assign stall_cnt_o = cnt_r;

endmodule
